rotate_cmd_sequencer: RTL and testbench
=======================================

ROTATE_CMD_SEQUENCER -- requirements
Module: rotate_cmd_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid, input, 1, command offered.
REQ-004 SHALL have port cmd_ready, output, 1, command slot available.
REQ-005 SHALL have port cmd_data, input, 8, byte to rotate.
REQ-006 SHALL have port cmd_amt, input, 3, rotate amount 0-7.
REQ-007 SHALL have port cmd_dir, input, 1, 0 = rotate right, 1 = rotate left.
REQ-008 SHALL have port rot_in, output, 8, registered data driven to the 8-bit right-rotator's data input.
REQ-009 SHALL have port rot_ctrl, output, 3, registered right-rotate amount driven to the rotator's control input.
REQ-010 SHALL have port rot_out, input, 8, combinational rotator result (rot_in rotated right by rot_ctrl).
REQ-011 SHALL have port res_valid, output, 1, result available.
REQ-012 SHALL have port res_ready, input, 1, downstream accepts result.
REQ-013 SHALL have port res_data, output, 8, registered rotation result.
REQ-014 SHALL have port res_count, output, 8, count of completed result handshakes.
REQ-015 SHALL have port busy, output, 1, high when state is not IDLE or the FIFO is non-empty.

Function
REQ-016 SHALL buffer commands (data, amt, dir) in a 4-entry FIFO with 3-bit occupancy 0..4.
REQ-017 SHALL drive cmd_ready = (occupancy < 4) from registered state only, with no combinational path from res_ready or the pop.
REQ-018 SHALL push when cmd_valid && cmd_ready; a simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-019 SHALL implement FSM states IDLE, ISSUE and HOLD.
REQ-020 IDLE: if the FIFO is non-empty, SHALL pop the head, load rot_in = data and rot_ctrl = converted amount, and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-021 ISSUE: SHALL capture rot_out into res_data, set res_valid, and go to HOLD (exactly one cycle).
REQ-022 HOLD: SHALL hold res_valid and res_data stable while res_ready = 0.
REQ-023 HOLD: on res_ready = 1, SHALL complete the handshake, increment res_count, and then either pop the next command and go to ISSUE with res_valid cleared (FIFO non-empty) or go to IDLE with res_valid cleared (FIFO empty).
REQ-024 SHALL convert the amount as: dir = 0 gives rot_ctrl = amt; dir = 1 gives rot_ctrl = (8 - amt) mod 8, the 3-bit two's complement of amt. Left amount 0 SHALL give rot_ctrl = 0.
REQ-025 Latency: a command accepted at edge N into an empty FIFO with state IDLE SHALL be popped at edge N+1 and have res_valid high after edge N+2.
REQ-026 Throughput: with res_ready held at 1, results SHALL issue once every 2 cycles.
REQ-027 res_count SHALL wrap from 255 to 0.
REQ-028 rot_in and rot_ctrl SHALL change only on a pop and SHALL otherwise hold their last value.
REQ-029 With res_ready = 0 and no pops, up to 5 commands SHALL be accepted (1 in the issue/result registers plus 4 in the FIFO) before cmd_ready falls.

Reset
REQ-030 While rst_n = 0, SHALL immediately force state IDLE, FIFO occupancy 0, rot_in = 0, rot_ctrl = 0, res_data = 0, res_valid = 0, res_count = 0, and busy = 0.
REQ-031 While rst_n = 0, cmd_ready SHALL be 1.
REQ-032 Reset asserted mid-operation SHALL discard all queued and in-flight commands with no result emitted.
REQ-033 After rst_n deasserts, the first command accepted SHALL follow REQ-025 timing.

Verification
REQ-034 SHALL cover: cmd 0xFE, right by 1, res_ready = 1 -> rot_ctrl = 1, res_data = 0x7F, res_valid high 2 cycles after acceptance, res_count = 1.
REQ-035 SHALL cover: cmd 0xFE, left by 1 -> rot_ctrl = 7, res_data = 0xFD; cmd 0x81, left by 0 -> rot_ctrl = 0, res_data = 0x81.
REQ-036 SHALL cover: res_ready = 0, offer 6 commands back-to-back -> 5 accepted, cmd_ready low from the cycle after the 5th; then res_ready = 1 -> 5 results in order, one every 2 cycles.
REQ-037 SHALL cover: res_ready toggling randomly during HOLD -> res_data stable until each handshake; no result lost or duplicated.
REQ-038 SHALL cover: rst_n pulsed low with 3 commands queued and res_valid high -> all outputs take reset values immediately and no stale result appears after release.
REQ-039 SHALL cover: 256 completed results -> res_count returns to 0.

Source files
------------

// File: rtl/rotate_cmd_sequencer.sv
// Command sequencer feeding an external 8-bit right-rotator: buffers rotate
// commands in a 4-deep FIFO, issues one at a time and returns registered results.
module rotate_cmd_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [2:0] cmd_amt,
    input  logic       cmd_dir,
    output logic [7:0] rot_in,
    output logic [2:0] rot_ctrl,
    input  logic [7:0] rot_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [7:0] res_count,
    output logic       busy
);
    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;
    localparam int DEPTH  = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_fifo_data [DEPTH];
    logic [AMT_W-1:0]    r_fifo_amt  [DEPTH];
    logic                r_fifo_dir  [DEPTH];
    logic [1:0]          r_wptr;
    logic [1:0]          r_rptr;
    logic [2:0]          r_occ;
    logic [DATA_W-1:0]   r_rot_in;
    logic [AMT_W-1:0]    r_rot_ctrl;
    logic [DATA_W-1:0]   r_res_data;
    logic                r_res_valid;
    logic [7:0]          r_res_count;

    logic                w_push;
    logic                w_pop;
    logic                w_nonempty;
    logic [DATA_W-1:0]   w_head_data;
    logic [AMT_W-1:0]    w_head_ctrl;

    // The rotator only rotates right; a left rotate by n is a right rotate by -n mod 8.
    function automatic logic [AMT_W-1:0] f_conv_amt(input logic [AMT_W-1:0] amt,
                                                    input logic dir);
        return dir ? -amt : amt;
    endfunction

    assign w_nonempty  = (r_occ != 3'd0);
    assign cmd_ready   = (r_occ < 3'd4);
    assign w_push      = cmd_valid && cmd_ready;
    assign w_pop       = w_nonempty &&
                         ((r_state == S_IDLE) || ((r_state == S_HOLD) && res_ready));
    assign w_head_data = r_fifo_data[r_rptr];
    assign w_head_ctrl = f_conv_amt(r_fifo_amt[r_rptr], r_fifo_dir[r_rptr]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wptr] <= cmd_data;
            r_fifo_amt[r_wptr]  <= cmd_amt;
            r_fifo_dir[r_wptr]  <= cmd_dir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= 2'd0;
            r_rptr <= 2'd0;
            r_occ  <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 3'd1;
                2'b01:   r_occ <= r_occ - 3'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rot_in    <= '0;
            r_rot_ctrl  <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_res_count <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_rot_in   <= w_head_data;
                        r_rot_ctrl <= w_head_ctrl;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_res_data  <= rot_out;
                    r_res_valid <= 1'b1;
                    r_state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_count <= r_res_count + 8'd1;
                        if (w_pop) begin
                            r_rot_in   <= w_head_data;
                            r_rot_ctrl <= w_head_ctrl;
                            r_state    <= S_ISSUE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rot_in    = r_rot_in;
    assign rot_ctrl  = r_rot_ctrl;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign res_count = r_res_count;
    assign busy      = (r_state != S_IDLE) || w_nonempty;

endmodule

// File: tb/tb_rotate_cmd_sequencer.sv
// Directed bench for rotate_cmd_sequencer with a behavioural right-rotator on rot_in/rot_ctrl.
module tb_rotate_cmd_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic       cmd_dir;
    logic [7:0] rot_in;
    logic [2:0] rot_ctrl;
    logic [7:0] rot_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [7:0] res_count;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rotr(input logic [7:0] v, input logic [2:0] s);
        logic [15:0] t;
        t = {v, v} >> s;
        return t[7:0];
    endfunction

    assign rot_out = rotr(rot_in, rot_ctrl);

    rotate_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_amt(cmd_amt), .cmd_dir(cmd_dir),
        .rot_in(rot_in), .rot_ctrl(rot_ctrl), .rot_out(rot_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_count(res_count), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [7:0] d, input logic [2:0] a, input logic dr);
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_dir = dr;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; cmd_amt = 3'd0;
        cmd_dir = 1'b0; res_ready = 1'b1;
        tick(); tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid got %b want 0", res_valid); end
        n_cmp++; if (res_count !== 8'h00) begin n_err++; $display("FAIL rst_res_count got %h want 00", res_count); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (rot_in !== 8'h00 || rot_ctrl !== 3'd0) begin n_err++; $display("FAIL rst_rot got %h/%0d want 00/0", rot_in, rot_ctrl); end
        n_cmp++; if (res_data !== 8'h00) begin n_err++; $display("FAIL rst_res_data got %h want 00", res_data); end
        rst_n = 1'b1;
        tick();
    endtask

    // Single command into an idle sequencer with res_ready held high.
    task automatic run_one(input string nm, input logic [7:0] d, input logic [2:0] a,
                           input logic dr, input logic [2:0] exp_ctrl,
                           input logic [7:0] exp_res, input logic [7:0] exp_cnt);
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_data = d; cmd_amt = a; cmd_dir = dr;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready got %b want 1", nm, cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL %s_n0 valid/busy got %b/%b want 0/1", nm, res_valid, busy); end
        tick();
        n_cmp++; if (rot_in !== d || rot_ctrl !== exp_ctrl) begin n_err++; $display("FAIL %s_rot got %h/%0d want %h/%0d", nm, rot_in, rot_ctrl, d, exp_ctrl); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL %s_n1 valid got %b want 0", nm, res_valid); end
        tick();
        n_cmp++; if (res_valid !== 1'b1 || res_data !== exp_res) begin n_err++; $display("FAIL %s_res got %b/%h want 1/%h", nm, res_valid, res_data, exp_res); end
        tick();
        n_cmp++; if (res_valid !== 1'b0 || res_count !== exp_cnt || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done valid/count/busy got %b/%0d/%b want 0/%0d/0", nm, res_valid, res_count, busy, exp_cnt);
        end
    endtask

    task automatic test_rotate();
        run_one("right1", 8'hFE, 3'd1, 1'b0, 3'd1, 8'h7F, 8'd1);
        run_one("left1",  8'hFE, 3'd1, 1'b1, 3'd7, 8'hFD, 8'd2);
        run_one("left0",  8'h81, 3'd0, 1'b1, 3'd0, 8'h81, 8'd3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d   [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        logic [2:0] a   [6] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd5};
        logic       dr  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] exq [5] = '{8'h80, 8'h08, 8'h30, 8'h20, 8'h05};
        res_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            cmd_valid = 1'b1; cmd_data = d[k]; cmd_amt = a[k]; cmd_dir = dr[k];
            n_cmp++;
            if (cmd_ready !== (k < 5)) begin n_err++; $display("FAIL b2b_ready%0d got %b want %b", k, cmd_ready, k < 5); end
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== 8'h80 || cmd_ready !== 1'b0) begin
                n_err++; $display("FAIL b2b_hold valid/data/ready got %b/%h/%b want 1/80/0", res_valid, res_data, cmd_ready);
            end
            tick();
        end
        res_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (res_valid !== 1'b1 || res_data !== exq[j]) begin n_err++; $display("FAIL b2b_res%0d got %b/%h want 1/%h", j, res_valid, res_data, exq[j]); end
            tick();
            n_cmp++;
            if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_gap%0d valid got %b want 0", j, res_valid); end
            if (j < 4) tick();
        end
        n_cmp++; if (res_count !== 8'd8 || busy !== 1'b0) begin n_err++; $display("FAIL b2b_count count/busy got %0d/%b want 8/0", res_count, busy); end
        tick(); tick();
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL b2b_extra valid got %b want 0", res_valid); end
    endtask

    task automatic test_random_ready();
        logic [7:0] exq [3] = '{8'h0F, 8'h5A, 8'h01};
        int  idx = 0;
        int  cyc = 0;
        logic hs;
        res_ready = 1'b0;
        push_cmd(8'h3C, 3'd2, 1'b0);
        push_cmd(8'hA5, 3'd4, 1'b1);
        push_cmd(8'h80, 3'd1, 1'b1);
        while (idx < 3 && cyc < 200) begin
            res_ready = 1'($urandom_range(0, 1));
            if (res_valid === 1'b1) begin
                n_cmp++;
                if (res_data !== exq[idx]) begin n_err++; $display("FAIL rnd_data%0d got %h want %h", idx, res_data, exq[idx]); end
            end
            hs = (res_valid === 1'b1) && res_ready;
            tick();
            cyc++;
            if (hs) idx++;
        end
        n_cmp++; if (idx != 3) begin n_err++; $display("FAIL rnd_timeout results got %0d want 3", idx); end
        res_ready = 1'b0;
        repeat (4) begin
            tick();
            n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rnd_dup valid got %b want 0", res_valid); end
        end
        n_cmp++; if (res_count !== 8'd11) begin n_err++; $display("FAIL rnd_count got %0d want 11", res_count); end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0;
        push_cmd(8'h11, 3'd1, 1'b0);
        push_cmd(8'h22, 3'd2, 1'b0);
        push_cmd(8'h33, 3'd3, 1'b0);
        push_cmd(8'h44, 3'd4, 1'b0);
        n_cmp++; if (res_valid !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre valid/busy got %b/%b want 1/1", res_valid, busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rmid_ctrl valid/busy/ready got %b/%b/%b want 0/0/1", res_valid, busy, cmd_ready);
        end
        n_cmp++; if (res_count !== 8'd0 || res_data !== 8'h00 || rot_in !== 8'h00 || rot_ctrl !== 3'd0) begin
            n_err++; $display("FAIL rmid_data count/res/rot_in/rot_ctrl got %0d/%h/%h/%0d want 0/00/00/0", res_count, res_data, rot_in, rot_ctrl);
        end
        tick(); tick();
        rst_n = 1'b1;
        res_ready = 1'b1;
        repeat (6) begin
            tick();
            n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rmid_stale valid/busy got %b/%b want 0/0", res_valid, busy); end
        end
        run_one("postrst", 8'h0F, 3'd4, 1'b1, 3'd4, 8'hF0, 8'd1);
    endtask

    task automatic test_count_wrap();
        int acc = 0;
        int hsn = 0;
        int cyc = 0;
        logic take, h;
        res_ready = 1'b1;
        while (hsn < 255 && cyc < 2000) begin
            cmd_valid = (acc < 255);
            cmd_data  = 8'(acc);
            cmd_amt   = 3'd0;
            cmd_dir   = 1'b0;
            take = cmd_valid && (cmd_ready === 1'b1);
            h    = (res_valid === 1'b1) && res_ready;
            if (h) begin
                n_cmp++;
                if (res_data !== 8'(hsn)) begin n_err++; $display("FAIL wrap_data%0d got %h want %h", hsn, res_data, 8'(hsn)); end
            end
            tick();
            cyc++;
            if (take) acc++;
            if (h) begin
                hsn++;
                if (hsn == 254) begin
                    n_cmp++;
                    if (res_count !== 8'd255) begin n_err++; $display("FAIL wrap_255 got %0d want 255", res_count); end
                end
            end
        end
        cmd_valid = 1'b0;
        n_cmp++; if (hsn != 255) begin n_err++; $display("FAIL wrap_timeout results got %0d want 255", hsn); end
        n_cmp++; if (res_count !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL wrap_zero count/busy got %0d/%b want 0/0", res_count, busy); end
    endtask

    initial begin
        test_reset();
        test_rotate();
        test_back_to_back();
        test_random_ready();
        test_reset_mid();
        test_count_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
